// File: rtl/umi_param_poller.sv
// Periodically reads one remote UMI register and keeps a local copy of its value.
// Also issues a poll immediately on trigger, and flags timeouts and unexpected responses.
module umi_param_poller #(
  parameter int          DW      = 32,
  parameter int          CW      = 32,
  parameter int          AW      = 64,
  parameter logic [63:0] DSTADDR = 64'h0,
  parameter logic [63:0] SRCADDR = 64'h0,
  parameter int          PERIOD  = 1024,
  parameter int          TIMEOUT = 4096
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic          enable,
  input  logic          trigger,
  output logic [DW-1:0] value,
  output logic          value_valid,
  output logic          update,
  output logic          busy,
  output logic          timeout_err,
  output logic          resp_err,
  output logic          uhost_req_valid,
  output logic [CW-1:0] uhost_req_cmd,
  output logic [AW-1:0] uhost_req_dstaddr,
  output logic [AW-1:0] uhost_req_srcaddr,
  output logic [DW-1:0] uhost_req_data,
  input  logic          uhost_req_ready,
  input  logic          uhost_resp_valid,
  input  logic [CW-1:0] uhost_resp_cmd,
  input  logic [AW-1:0] uhost_resp_dstaddr,
  input  logic [AW-1:0] uhost_resp_srcaddr,
  input  logic [DW-1:0] uhost_resp_data,
  output logic          uhost_resp_ready
);

  localparam logic [31:0]   PERIOD_LOAD  = 32'(PERIOD - 1);
  localparam logic [31:0]   TIMEOUT_LOAD = 32'(TIMEOUT - 1);
  localparam logic [2:0]    REQ_SIZE     = 3'($clog2(DW / 8));
  // Read request: opcode REQ_READ, size log2(DW/8), len 0, all other fields zero.
  localparam logic [CW-1:0] REQ_CMD      = CW'({REQ_SIZE, 5'h01});
  localparam logic [4:0]    RESP_READ    = 5'h02;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_REQ,
    S_RESP
  } state_t;

  state_t      state;
  state_t      next_state;
  logic [31:0] timer;
  logic        timer_zero;
  logic        resp_seen;
  logic        resp_ok;
  logic        resp_done;
  logic        timed_out;
  logic        unused_ok;

  assign timer_zero = (timer == 32'd0);
  // Only responses seen in RESP count; anything else is accepted and dropped.
  assign resp_seen  = (state == S_RESP) && uhost_resp_valid;
  assign resp_ok    = resp_seen && (uhost_resp_cmd[4:0] == RESP_READ);
  assign resp_done  = (state == S_RESP) && (uhost_resp_valid || timer_zero);
  assign timed_out  = (state == S_RESP) && !uhost_resp_valid && timer_zero;

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (trigger)      next_state = S_REQ;
        else if (enable)  next_state = S_WAIT;
      end
      S_WAIT: begin
        if (trigger)         next_state = S_REQ;
        else if (!enable)    next_state = S_IDLE;
        else if (timer_zero) next_state = S_REQ;
      end
      S_REQ: begin
        if (uhost_req_ready) next_state = S_RESP;
      end
      S_RESP: begin
        if (resp_done) next_state = enable ? S_WAIT : S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) state <= S_IDLE;
    else         state <= next_state;
  end

  // One counter serves as the poll period timer and as the response timeout.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      timer <= 32'd0;
    end else begin
      case (state)
        S_IDLE: timer <= PERIOD_LOAD;
        S_WAIT: if (!timer_zero) timer <= timer - 32'd1;
        S_REQ:  if (uhost_req_ready) timer <= TIMEOUT_LOAD;
        S_RESP: timer <= resp_done ? PERIOD_LOAD : timer - 32'd1;
        default: timer <= 32'd0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      value       <= '0;
      value_valid <= 1'b0;
      update      <= 1'b0;
      timeout_err <= 1'b0;
      resp_err    <= 1'b0;
    end else begin
      update <= resp_ok;
      if (resp_ok) begin
        value       <= uhost_resp_data;
        value_valid <= 1'b1;
      end
      if (resp_seen && !resp_ok) resp_err <= 1'b1;
      if (timed_out)             timeout_err <= 1'b1;
    end
  end

  assign uhost_req_valid   = (state == S_REQ);
  assign uhost_req_cmd     = REQ_CMD;
  assign uhost_req_dstaddr = AW'(DSTADDR);
  assign uhost_req_srcaddr = AW'(SRCADDR);
  assign uhost_req_data    = '0;
  assign busy              = (state == S_REQ) || (state == S_RESP);
  assign uhost_resp_ready  = nreset;

  assign unused_ok = ^{uhost_resp_cmd[CW-1:5], uhost_resp_dstaddr, uhost_resp_srcaddr};

endmodule

// File: tb/tb_umi_param_poller.sv
// Scoreboard bench for umi_param_poller: expected requests and value updates are queued by
// the stimulus thread and popped by a monitor whenever the DUT hands shakes or pulses update.
module tb_umi_param_poller;

  localparam int          DW      = 32;
  localparam int          CW      = 32;
  localparam int          AW      = 64;
  localparam int          PERIOD  = 8;
  localparam int          TIMEOUT = 16;
  localparam logic [63:0] DST     = 64'h1234_5678_9ABC_DEF0;
  localparam logic [63:0] SRC     = 64'h0000_0000_0000_0A00;
  localparam logic [31:0] EXP_CMD = 32'h0000_0041;

  typedef struct packed {
    logic [CW-1:0] cmd;
    logic [AW-1:0] dst;
    logic [AW-1:0] src;
    logic [DW-1:0] data;
  } req_t;

  localparam req_t EXP_REQ = '{cmd: EXP_CMD, dst: DST, src: SRC, data: 32'h0};

  logic          clk;
  logic          nreset;
  logic          enable;
  logic          trigger;
  logic [DW-1:0] value;
  logic          value_valid;
  logic          update;
  logic          busy;
  logic          timeout_err;
  logic          resp_err;
  logic          uhost_req_valid;
  logic [CW-1:0] uhost_req_cmd;
  logic [AW-1:0] uhost_req_dstaddr;
  logic [AW-1:0] uhost_req_srcaddr;
  logic [DW-1:0] uhost_req_data;
  logic          uhost_req_ready;
  logic          uhost_resp_valid;
  logic [CW-1:0] uhost_resp_cmd;
  logic [AW-1:0] uhost_resp_dstaddr;
  logic [AW-1:0] uhost_resp_srcaddr;
  logic [DW-1:0] uhost_resp_data;
  logic          uhost_resp_ready;

  req_t          exp_req_q[$];
  logic [DW-1:0] exp_val_q[$];
  req_t          mon_req;
  logic [DW-1:0] mon_val;
  int            tests_run = 0;
  int            failed    = 0;
  int            hs_count  = 0;
  int            cyc       = 0;

  umi_param_poller #(
    .DW(DW), .CW(CW), .AW(AW), .DSTADDR(DST), .SRCADDR(SRC),
    .PERIOD(PERIOD), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .nreset(nreset), .enable(enable), .trigger(trigger),
    .value(value), .value_valid(value_valid), .update(update), .busy(busy),
    .timeout_err(timeout_err), .resp_err(resp_err),
    .uhost_req_valid(uhost_req_valid), .uhost_req_cmd(uhost_req_cmd),
    .uhost_req_dstaddr(uhost_req_dstaddr), .uhost_req_srcaddr(uhost_req_srcaddr),
    .uhost_req_data(uhost_req_data), .uhost_req_ready(uhost_req_ready),
    .uhost_resp_valid(uhost_resp_valid), .uhost_resp_cmd(uhost_resp_cmd),
    .uhost_resp_dstaddr(uhost_resp_dstaddr), .uhost_resp_srcaddr(uhost_resp_srcaddr),
    .uhost_resp_data(uhost_resp_data), .uhost_resp_ready(uhost_resp_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every request handshake and every update pulse consumes one scoreboard entry.
  always @(negedge clk) begin
    if (nreset && uhost_req_valid && uhost_req_ready) begin
      hs_count++;
      if (exp_req_q.size() == 0) begin
        check_output("unexpected_request", 64'(hs_count), 64'd0);
      end else begin
        mon_req = exp_req_q.pop_front();
        check_output("req_cmd", 64'(uhost_req_cmd), 64'(mon_req.cmd));
        check_output("req_dstaddr", uhost_req_dstaddr, mon_req.dst);
        check_output("req_srcaddr", uhost_req_srcaddr, mon_req.src);
        check_output("req_data", 64'(uhost_req_data), 64'(mon_req.data));
      end
    end
    if (nreset && update) begin
      if (exp_val_q.size() == 0) begin
        check_output("unexpected_update", 64'(value), 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        mon_val = exp_val_q.pop_front();
        check_output("update_value", 64'(value), 64'(mon_val));
      end
    end
  end

  task automatic pulse_trigger(output int t);
    @(posedge clk); #1;
    trigger = 1'b1;
    t = cyc;
    @(posedge clk); #1;
    trigger = 1'b0;
  endtask

  task automatic wait_req_valid(output int c);
    bit found;
    found = 1'b0;
    c = -1;
    for (int i = 0; i < 300; i++) begin
      if (!found) begin
        @(negedge clk);
        if (uhost_req_valid) begin
          found = 1'b1;
          c = cyc;
        end
      end
    end
    if (!found) check_output("request_wait_expired", 64'd0, 64'd1);
  endtask

  task automatic apply_stimulus(input logic [4:0] op, input logic [31:0] d);
    @(posedge clk); #1;
    uhost_resp_valid = 1'b1;
    uhost_resp_cmd   = 32'({3'd2, op});
    uhost_resp_data  = d;
    @(posedge clk); #1;
    uhost_resp_valid = 1'b0;
    uhost_resp_cmd   = '0;
    uhost_resp_data  = '0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_output({tag, "_req_valid"}, 64'(uhost_req_valid), 64'd0);
    check_output({tag, "_busy"}, 64'(busy), 64'd0);
    check_output({tag, "_value"}, 64'(value), 64'd0);
    check_output({tag, "_flags"}, 64'({value_valid, update, timeout_err, resp_err}), 64'd0);
    check_output({tag, "_resp_ready"}, 64'(uhost_resp_ready), 64'd0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int e, c, c2, t, h, v, n, hs0, bad;
    logic [CW-1:0] s_cmd;
    logic [AW-1:0] s_dst, s_src;
    logic [DW-1:0] s_data;

    nreset = 1'b0; enable = 1'b0; trigger = 1'b0; uhost_req_ready = 1'b1;
    uhost_resp_valid = 1'b0; uhost_resp_cmd = '0; uhost_resp_data = '0;
    uhost_resp_dstaddr = SRC; uhost_resp_srcaddr = DST;

    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;
    nreset = 1'b1;
    #1 check_output("resp_ready_after_reset", 64'(uhost_resp_ready), 64'd1);

    // Periodic polling with the endpoint always ready.
    exp_req_q.push_back(EXP_REQ);
    @(posedge clk); #1;
    enable = 1'b1;
    e = cyc;
    wait_req_valid(c);
    check_output("first_poll_latency", 64'(c - e), 64'(PERIOD + 1));
    exp_val_q.push_back(32'hDEAD_BEEF);
    apply_stimulus(5'h02, 32'hDEAD_BEEF);
    @(negedge clk);
    check_output("update_pulse", 64'(update), 64'd1);
    check_output("value_after_read", 64'(value), 64'hDEAD_BEEF);
    check_output("value_valid_set", 64'(value_valid), 64'd1);
    @(negedge clk);
    check_output("update_one_cycle", 64'(update), 64'd0);
    exp_req_q.push_back(EXP_REQ);
    wait_req_valid(c2);
    check_output("poll_period", 64'(c2 - (c + 1)), 64'(PERIOD + 1));
    enable = 1'b0;
    exp_val_q.push_back(32'h0123_4567);
    apply_stimulus(5'h02, 32'h0123_4567);
    @(negedge clk);
    check_output("idle_after_disable", 64'(busy), 64'd0);

    // Single triggered poll, then silence.
    exp_req_q.push_back(EXP_REQ);
    pulse_trigger(t);
    wait_req_valid(c);
    check_output("trigger_latency", 64'(c - t), 64'd1);
    exp_val_q.push_back(32'h55AA_33CC);
    apply_stimulus(5'h02, 32'h55AA_33CC);
    n = 0;
    repeat (100) begin
      @(negedge clk);
      if (uhost_req_valid) n++;
    end
    check_output("no_requests_after_trigger", 64'(n), 64'd0);
    check_output("trigger_value", 64'(value), 64'h55AA_33CC);

    // Backpressure: request must hold steady while ready is low.
    @(posedge clk); #1;
    uhost_req_ready = 1'b0;
    hs0 = hs_count;
    pulse_trigger(t);
    wait_req_valid(v);
    s_cmd = uhost_req_cmd; s_dst = uhost_req_dstaddr; s_src = uhost_req_srcaddr; s_data = uhost_req_data;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      if (uhost_req_valid !== 1'b1 || uhost_req_cmd !== s_cmd || uhost_req_dstaddr !== s_dst ||
          uhost_req_srcaddr !== s_src || uhost_req_data !== s_data) bad++;
    end
    check_output("backpressure_stable", 64'(bad), 64'd0);
    check_output("no_transfer_while_stalled", 64'(hs_count - hs0), 64'd0);
    exp_req_q.push_back(EXP_REQ);
    @(posedge clk); #1;
    uhost_req_ready = 1'b1;
    exp_val_q.push_back(32'hCAFE_0003);
    apply_stimulus(5'h02, 32'hCAFE_0003);
    @(negedge clk);
    check_output("single_transfer", 64'(hs_count - hs0), 64'd1);

    // Timeout, then a late response in WAIT that must be ignored.
    exp_req_q.push_back(EXP_REQ);
    pulse_trigger(t);
    wait_req_valid(h);
    @(posedge clk); #1;
    enable = 1'b1;
    repeat (TIMEOUT) @(negedge clk);
    check_output("timeout_not_early", 64'(timeout_err), 64'd0);
    check_output("busy_while_waiting", 64'(busy), 64'd1);
    @(negedge clk);
    check_output("timeout_err_set", 64'(timeout_err), 64'd1);
    check_output("value_after_timeout", 64'(value), 64'hCAFE_0003);
    exp_req_q.push_back(EXP_REQ);
    @(posedge clk); #1;
    uhost_resp_valid = 1'b1;
    uhost_resp_cmd   = 32'({3'd2, 5'h02});
    uhost_resp_data  = 32'hBAD0_BAD0;
    @(posedge clk); #1;
    uhost_resp_valid = 1'b0;
    uhost_resp_cmd   = '0;
    uhost_resp_data  = '0;
    @(negedge clk);
    check_output("late_resp_value", 64'(value), 64'hCAFE_0003);
    check_output("late_resp_no_err", 64'(resp_err), 64'd0);
    wait_req_valid(c);
    check_output("poll_resumes", 64'(c - (h + TIMEOUT)), 64'(PERIOD + 1));

    // Error opcode in RESP.
    enable = 1'b0;
    apply_stimulus(5'h04, 32'hFFFF_FFFF);
    @(negedge clk);
    check_output("resp_err_set", 64'(resp_err), 64'd1);
    check_output("resp_err_value", 64'(value), 64'hCAFE_0003);
    check_output("resp_err_no_update", 64'(update), 64'd0);
    check_output("timeout_err_sticky", 64'(timeout_err), 64'd1);

    // Reset while waiting for a response.
    exp_req_q.push_back(EXP_REQ);
    pulse_trigger(t);
    wait_req_valid(h);
    @(posedge clk); #1;
    check_output("busy_in_resp", 64'(busy), 64'd1);
    nreset = 1'b0;
    #1 check_reset_outputs("reset_in_resp");
    repeat (2) @(posedge clk);
    #1 nreset = 1'b1;
    n = 0;
    repeat (20) begin
      @(negedge clk);
      if (uhost_req_valid) n++;
    end
    check_output("quiet_after_reset_resp", 64'(n), 64'd0);

    // Reset while a request is stalled.
    uhost_req_ready = 1'b0;
    pulse_trigger(t);
    wait_req_valid(v);
    @(posedge clk); #1;
    check_output("valid_held", 64'(uhost_req_valid), 64'd1);
    nreset = 1'b0;
    #1 check_reset_outputs("reset_in_req");
    repeat (2) @(posedge clk);
    #1 nreset = 1'b1;
    uhost_req_ready = 1'b1;
    n = 0;
    repeat (20) begin
      @(negedge clk);
      if (uhost_req_valid) n++;
    end
    check_output("quiet_after_reset_req", 64'(n), 64'd0);
    exp_req_q.push_back(EXP_REQ);
    @(posedge clk); #1;
    enable = 1'b1;
    e = cyc;
    wait_req_valid(c);
    check_output("poll_after_reset", 64'(c - e), 64'(PERIOD + 1));
    enable = 1'b0;
    exp_val_q.push_back(32'h7777_1234);
    apply_stimulus(5'h02, 32'h7777_1234);
    @(negedge clk);
    check_output("final_value", 64'(value), 64'h7777_1234);
    check_output("final_value_valid", 64'(value_valid), 64'd1);

    repeat (3) @(negedge clk);
    check_output("pending_requests", 64'(exp_req_q.size()), 64'd0);
    check_output("pending_updates", 64'(exp_val_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
